// File: rtl/mem_request_arbiter_if.sv
// =============================================================================
// Module      : mem_request_arbiter_if
// Description : Request/response and single-port RAM bus of the memory arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface mem_request_arbiter_if;
    logic        iren;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  svsel;
    logic [1:0]  ldsel;
    logic        dhit;
    logic [31:0] dload;
    logic        halt;
    logic        halted;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramload;
    logic        ramready;

    modport slave (
        input  iren, iaddr, dren, dwen, daddr, dstore, svsel, ldsel, halt,
               ramload, ramready,
        output ihit, iload, dhit, dload, halted, ramaddr, ramstore, ramREN, ramWEN
    );

    modport master (
        output iren, iaddr, dren, dwen, daddr, dstore, svsel, ldsel, halt,
               ramload, ramready,
        input  ihit, iload, dhit, dload, halted, ramaddr, ramstore, ramREN, ramWEN
    );
endinterface

`default_nettype wire

// File: rtl/mem_request_arbiter.sv
// =============================================================================
// Module      : mem_request_arbiter
// Description : Arbitrates fetch/load/store requests onto one word-addressed RAM,
//               with sub-word load extraction, byte/halfword RMW and sticky halt.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_request_arbiter #(
    parameter int DPRIORITY = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    mem_request_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        RMW_RD = 3'd4,
        RMW_WR = 3'd5,
        HALTED = 3'd6
    } state_t;

    localparam logic c_DATA_FIRST = (DPRIORITY != 0);

    state_t      r_state;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic [15:0] r_lane;
    logic        r_rr_data;

    logic        w_i_elig;
    logic        w_d_elig;
    logic        w_tie;
    logic        w_grant_d;
    logic        w_grant_i;
    logic [31:0] w_shift_b;
    logic [31:0] w_shift_h;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    // A port still showing its hit is ineligible, so a held request is not re-accepted.
    assign w_i_elig  = bus.iren & ~bus.ihit;
    assign w_d_elig  = (bus.dren | bus.dwen) & ~bus.dhit;
    assign w_tie     = w_i_elig & w_d_elig;
    assign w_grant_d = w_d_elig & (~w_i_elig | c_DATA_FIRST | r_rr_data);
    assign w_grant_i = w_i_elig & ~w_grant_d;

    always_comb begin
        w_shift_b = bus.ramload >> {r_off, 3'b000};
        w_shift_h = bus.ramload >> {r_off[1], 4'b0000};
        case (r_size)
            2'd1:    w_load = {24'd0, w_shift_b[7:0]};
            2'd2:    w_load = {16'd0, w_shift_h[15:0]};
            default: w_load = bus.ramload;
        endcase
    end

    always_comb begin
        w_merged = bus.ramload;
        if (r_size == 2'd1) begin
            w_merged[{r_off, 3'b000} +: 8] = r_lane[7:0];
        end else begin
            w_merged[{r_off[1], 4'b0000} +: 16] = r_lane;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_off        <= 2'd0;
            r_size       <= 2'd0;
            r_lane       <= 16'd0;
            r_rr_data    <= 1'b0;
            bus.ihit     <= 1'b0;
            bus.dhit     <= 1'b0;
            bus.halted   <= 1'b0;
            bus.ramREN   <= 1'b0;
            bus.ramWEN   <= 1'b0;
            bus.iload    <= 32'd0;
            bus.dload    <= 32'd0;
            bus.ramaddr  <= 32'd0;
            bus.ramstore <= 32'd0;
        end else begin
            bus.ihit <= 1'b0;
            bus.dhit <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.halt) begin
                        r_state    <= HALTED;
                        bus.halted <= 1'b1;
                    end else if (w_grant_d) begin
                        r_off       <= bus.daddr[1:0];
                        r_lane      <= bus.dstore[15:0];
                        bus.ramaddr <= bus.daddr & ~32'd3;
                        if (w_tie) begin
                            r_rr_data <= 1'b0;
                        end
                        if (bus.dwen) begin
                            r_size <= bus.svsel;
                            if (bus.svsel == 2'd1 || bus.svsel == 2'd2) begin
                                r_state    <= RMW_RD;
                                bus.ramREN <= 1'b1;
                            end else begin
                                r_state      <= DWRITE;
                                bus.ramWEN   <= 1'b1;
                                bus.ramstore <= bus.dstore;
                            end
                        end else begin
                            r_size     <= bus.ldsel;
                            r_state    <= DREAD;
                            bus.ramREN <= 1'b1;
                        end
                    end else if (w_grant_i) begin
                        r_state     <= IFETCH;
                        bus.ramREN  <= 1'b1;
                        bus.ramaddr <= bus.iaddr & ~32'd3;
                        if (w_tie) begin
                            r_rr_data <= 1'b1;
                        end
                    end
                end
                IFETCH: begin
                    if (bus.ramready) begin
                        r_state    <= IDLE;
                        bus.ramREN <= 1'b0;
                        bus.iload  <= bus.ramload;
                        bus.ihit   <= 1'b1;
                    end
                end
                DREAD: begin
                    if (bus.ramready) begin
                        r_state    <= IDLE;
                        bus.ramREN <= 1'b0;
                        bus.dload  <= w_load;
                        bus.dhit   <= 1'b1;
                    end
                end
                DWRITE: begin
                    if (bus.ramready) begin
                        r_state    <= IDLE;
                        bus.ramWEN <= 1'b0;
                        bus.dhit   <= 1'b1;
                    end
                end
                RMW_RD: begin
                    if (bus.ramready) begin
                        r_state      <= RMW_WR;
                        bus.ramREN   <= 1'b0;
                        bus.ramWEN   <= 1'b1;
                        bus.ramstore <= w_merged;
                    end
                end
                RMW_WR: begin
                    if (bus.ramready) begin
                        r_state    <= IDLE;
                        bus.ramWEN <= 1'b0;
                        bus.dhit   <= 1'b1;
                    end
                end
                HALTED: begin
                    r_state <= HALTED;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
// =============================================================================
// Module      : tb_mem_request_arbiter
// Description : Directed, table-driven bench for mem_request_arbiter.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_mem_request_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mem_request_arbiter_if bus();
    mem_request_arbiter_if bus_rr();

    mem_request_arbiter #(.DPRIORITY(1)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    mem_request_arbiter #(.DPRIORITY(0)) u_dut_rr (
        .CLK (clk),
        .RST (rst),
        .bus (bus_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic [31:0] exp_word;
        logic [31:0] exp_addr;
        int          exp_lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] last_dload;
        logic [31:0] rr_addr [3];
        logic [1:0]  rr_hit  [3];
        logic [1:0]  order   [2];
        int          lat;
        int          wen_cnt;
        int          nhits;
        logic        got;

        n_vec = 0;
        n_err = 0;
        last_dload = 32'd0;

        // reads use ramload 0x11223344 unless noted; stores show the written word
        vecs[0]  = '{1'b0, 32'h203, 2'd1, 32'h0,        32'h11223344, 32'h00000011, 32'h200, 2};
        vecs[1]  = '{1'b0, 32'h202, 2'd2, 32'h0,        32'h11223344, 32'h00001122, 32'h200, 2};
        vecs[2]  = '{1'b0, 32'h200, 2'd1, 32'h0,        32'h11223344, 32'h00000044, 32'h200, 2};
        vecs[3]  = '{1'b0, 32'h201, 2'd2, 32'h0,        32'h11223344, 32'h00003344, 32'h200, 2};
        vecs[4]  = '{1'b0, 32'h20E, 2'd3, 32'h0,        32'h11223344, 32'h11223344, 32'h20C, 2};
        vecs[5]  = '{1'b0, 32'h300, 2'd0, 32'h0,        32'hA5A50F0F, 32'hA5A50F0F, 32'h300, 2};
        vecs[6]  = '{1'b1, 32'h041, 2'd1, 32'h000000AB, 32'h11223344, 32'h1122AB44, 32'h040, 3};
        vecs[7]  = '{1'b1, 32'h042, 2'd2, 32'hFFFFBEEF, 32'h11223344, 32'hBEEF3344, 32'h040, 3};
        vecs[8]  = '{1'b1, 32'h043, 2'd1, 32'h000000CD, 32'h11223344, 32'hCD223344, 32'h040, 3};
        vecs[9]  = '{1'b1, 32'h082, 2'd0, 32'hCAFEF00D, 32'h11223344, 32'hCAFEF00D, 32'h080, 2};
        vecs[10] = '{1'b1, 32'h084, 2'd3, 32'h12345678, 32'h99999999, 32'h12345678, 32'h084, 2};

        rr_addr = '{32'h20, 32'h10, 32'h20};
        rr_hit  = '{2'b10, 2'b01, 2'b10};

        rst = 1'b1;
        bus.iren = 0; bus.iaddr = 0; bus.dren = 0; bus.dwen = 0; bus.daddr = 0;
        bus.dstore = 0; bus.svsel = 0; bus.ldsel = 0; bus.halt = 0;
        bus.ramload = 0; bus.ramready = 0;
        bus_rr.iren = 0; bus_rr.iaddr = 0; bus_rr.dren = 0; bus_rr.dwen = 0; bus_rr.daddr = 0;
        bus_rr.dstore = 0; bus_rr.svsel = 0; bus_rr.ldsel = 0; bus_rr.halt = 0;
        bus_rr.ramload = 0; bus_rr.ramready = 0;

        // reset state
        @(negedge clk);
        check("rst_flags", {27'd0, bus.ihit, bus.dhit, bus.halted, bus.ramREN, bus.ramWEN}, 32'd0);
        check("rst_iload", bus.iload, 32'd0);
        check("rst_dload", bus.dload, 32'd0);
        check("rst_ramaddr", bus.ramaddr, 32'd0);
        check("rst_ramstore", bus.ramstore, 32'd0);
        rst = 1'b0;

        // word fetch, zero-wait RAM
        @(negedge clk);
        bus.ramready = 1; bus.ramload = 32'hDEADBEEF; bus.iren = 1; bus.iaddr = 32'h104;
        @(negedge clk);
        bus.iren = 0;
        check("fetch_ramREN", {31'd0, bus.ramREN}, 32'd1);
        check("fetch_ramaddr", bus.ramaddr, 32'h104);
        check("fetch_early_ihit", {31'd0, bus.ihit}, 32'd0);
        @(negedge clk);
        check("fetch_ihit", {31'd0, bus.ihit}, 32'd1);
        check("fetch_iload", bus.iload, 32'hDEADBEEF);
        check("fetch_ramREN_off", {31'd0, bus.ramREN}, 32'd0);
        @(negedge clk);
        check("fetch_ihit_pulse", {31'd0, bus.ihit}, 32'd0);

        // table-driven loads and stores
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            bus.dren = ~vecs[v].wr; bus.dwen = vecs[v].wr; bus.daddr = vecs[v].addr;
            bus.ldsel = vecs[v].sz; bus.svsel = vecs[v].sz; bus.dstore = vecs[v].wdata;
            bus.ramload = vecs[v].mem; bus.ramready = 1;
            got = 0; lat = 0; wen_cnt = 0;
            while (!got && lat < 8) begin
                @(negedge clk);
                lat++;
                bus.dren = 0; bus.dwen = 0;
                check("vec_strobe_excl", {31'd0, bus.ramREN & bus.ramWEN}, 32'd0);
                check("vec_ihit_quiet", {31'd0, bus.ihit}, 32'd0);
                if (bus.ramREN || bus.ramWEN) check("vec_ramaddr", bus.ramaddr, vecs[v].exp_addr);
                if (bus.ramWEN) begin
                    wen_cnt++;
                    check("vec_ramstore", bus.ramstore, vecs[v].exp_word);
                end
                if (bus.dhit) begin
                    got = 1;
                    if (vecs[v].wr) begin
                        check("vec_dload_kept", bus.dload, last_dload);
                    end else begin
                        check("vec_dload", bus.dload, vecs[v].exp_word);
                        last_dload = vecs[v].exp_word;
                    end
                end
            end
            check("vec_latency", lat, vecs[v].exp_lat);
            check("vec_wen_cycles", wen_cnt, vecs[v].wr ? 32'd1 : 32'd0);
        end

        // byte store RMW with three wait cycles per phase
        @(negedge clk);
        bus.ramready = 0; bus.ramload = 32'h11223344;
        bus.dwen = 1; bus.daddr = 32'h41; bus.svsel = 2'd1; bus.dstore = 32'hAB;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.dwen = 0;
            check("rmw_rd_hold", {30'd0, bus.ramREN, bus.ramWEN}, 32'b10);
            check("rmw_rd_addr", bus.ramaddr, 32'h40);
        end
        bus.ramready = 1;
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            bus.ramready = (k == 6);
            check("rmw_wr_hold", {30'd0, bus.ramREN, bus.ramWEN}, 32'b01);
            check("rmw_wr_data", bus.ramstore, 32'h1122AB44);
            check("rmw_wr_nohit", {31'd0, bus.dhit}, 32'd0);
        end
        @(negedge clk);
        bus.ramready = 1;
        check("rmw_dhit", {29'd0, bus.dhit, bus.ramREN, bus.ramWEN}, 32'b100);

        // tie with data priority: data first, then instruction
        @(negedge clk);
        bus.ramload = 32'h55; bus.iaddr = 32'h20; bus.daddr = 32'h10; bus.ldsel = 2'd0;
        bus.iren = 1; bus.dren = 1;
        nhits = 0;
        order = '{2'b00, 2'b00};
        for (int c = 0; c < 12 && nhits < 2; c++) begin
            @(negedge clk);
            check("tie_hit_excl", {31'd0, bus.ihit & bus.dhit}, 32'd0);
            if (bus.dhit) begin order[nhits] = 2'b01; nhits++; bus.dren = 0; end
            if (bus.ihit) begin order[nhits] = 2'b10; nhits++; bus.iren = 0; end
        end
        bus.iren = 0; bus.dren = 0;
        check("tie_first", {30'd0, order[0]}, 32'b01);
        check("tie_second", {30'd0, order[1]}, 32'b10);

        // round-robin ties: instruction, data, instruction
        bus_rr.ramready = 1; bus_rr.iaddr = 32'h20; bus_rr.daddr = 32'h10;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            bus_rr.iren = 1; bus_rr.dren = 1;
            @(negedge clk);
            bus_rr.iren = 0; bus_rr.dren = 0;
            check("rr_grant_addr", bus_rr.ramaddr, rr_addr[t]);
            @(negedge clk);
            check("rr_hit", {30'd0, bus_rr.ihit, bus_rr.dhit}, {30'd0, rr_hit[t]});
        end

        // halt in IDLE beats a simultaneous fetch
        @(negedge clk);
        bus.halt = 1; bus.iren = 1; bus.iaddr = 32'h500;
        @(negedge clk);
        bus.halt = 0; bus.dren = 1;
        check("halt_idle_halted", {31'd0, bus.halted}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("halt_parked", {28'd0, bus.halted, bus.ramREN, bus.ramWEN, bus.ihit | bus.dhit}, 32'b1000);
        end
        bus.iren = 0; bus.dren = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("halt_cleared", {31'd0, bus.halted}, 32'd0);

        // halt during a word write: write finishes, dhit, then parked
        @(negedge clk);
        bus.ramready = 0; bus.dwen = 1; bus.daddr = 32'h100; bus.svsel = 2'd0; bus.dstore = 32'h77;
        @(negedge clk);
        bus.dwen = 0; bus.halt = 1;
        check("halt_dw_wen", {31'd0, bus.ramWEN}, 32'd1);
        @(negedge clk);
        bus.ramready = 1;
        check("halt_dw_held", {30'd0, bus.ramWEN, bus.halted}, 32'b10);
        @(negedge clk);
        bus.ramready = 0;
        check("halt_dw_dhit", {29'd0, bus.dhit, bus.halted, bus.ramWEN}, 32'b100);
        @(negedge clk);
        bus.halt = 0;
        check("halt_dw_parked", {30'd0, bus.halted, bus.dhit}, 32'b10);
        @(negedge clk);
        @(negedge clk);
        check("halt_dw_sticky", {31'd0, bus.halted}, 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;

        // reset asserted mid-RMW read
        @(negedge clk);
        bus.ramready = 0; bus.dwen = 1; bus.daddr = 32'h41; bus.svsel = 2'd1; bus.dstore = 32'hAB;
        @(negedge clk);
        bus.dwen = 0;
        check("rstmid_ren", {31'd0, bus.ramREN}, 32'd1);
        #2 rst = 1;
        #1 check("rstmid_async_drop", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        @(negedge clk);
        bus.ramready = 1;
        rst = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rstmid_quiet", {29'd0, bus.ramREN, bus.ramWEN, bus.dhit}, 32'd0);
        end
        bus.iren = 1; bus.iaddr = 32'h608;
        @(negedge clk);
        bus.iren = 0;
        check("rstmid_idle_accept", {31'd0, bus.ramREN}, 32'd1);
        check("rstmid_idle_addr", bus.ramaddr, 32'h608);
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Responder for the fetch/load/store requests issued by the datapath's control decode (`iread`, `dread`, `dwrite`, `LDsel`, `SVsel`, `halt`). It arbitrates instruction and data requests onto one word-addressed, single-ported RAM with a ready handshake. It performs sub-word load extraction and read-modify-write for byte and halfword stores. It returns single-cycle hit pulses with registered data, and it parks the memory system permanently once halt is seen.

## Interface
Parameters:
- `DPRIORITY`, default 1. When 1, data wins simultaneous requests. When 0, ties alternate round-robin, starting with instruction.

Ports:
- `CLK` in 1: clock. All state changes on the rising edge.
- `RST` in 1: reset. One clock; reset is asynchronous and active-high.
- `iren` in 1: instruction fetch request.
- `iaddr` in 32: fetch byte address.
- `ihit` out 1: one-cycle pulse; `iload` is valid in the same cycle.
- `iload` out 32: fetched word.
- `dren` in 1: data read request.
- `dwen` in 1: data write request. If `dren` is also high, `dwen` wins.
- `daddr` in 32: data byte address.
- `dstore` in 32: store data, right-aligned for byte and halfword stores.
- `svsel` in 2: store size. 0 = word, 1 = byte, 2 = halfword, 3 = word.
- `ldsel` in 2: load size. 0 = word, 1 = byte zero-extended, 2 = halfword zero-extended, 3 = word.
- `dhit` out 1: one-cycle pulse; `dload` is valid in the same cycle.
- `dload` out 32: load result.
- `halt` in 1: stop request.
- `halted` out 1: sticky; high once the block is parked.
- `ramaddr` out 32: word address, `{addr[31:2],2'b00}`.
- `ramstore` out 32: RAM write data.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramload` in 32: RAM read data. Valid when `ramready` is high during a read.
- `ramready` in 1: RAM access completes this cycle.

## Operation
- States: IDLE, IFETCH, DREAD, DWRITE, RMW_RD, RMW_WR, HALTED.
- Reset: state IDLE, round-robin pointer set to instruction.
- Reset values of outputs:
  - `ihit`, `dhit`, `halted`, `ramREN`, `ramWEN` = 0.
  - `iload`, `dload`, `ramaddr`, `ramstore` = 0.
- IDLE, in priority order:
  - `halt` high → go to HALTED. This takes precedence over any request in the same cycle.
  - Otherwise select a request. Candidates are `dwen`/`dren` and `iren`.
  - A port whose hit output is high in this cycle is not eligible, so a held request is not double-accepted.
  - On accept, latch address, size, store data and kind.
  - Next state is IFETCH, DREAD, DWRITE (svsel 0/3) or RMW_RD (svsel 1/2).
- After acceptance the requester may drop the request; the response is still returned.
- IFETCH and DREAD:
  - `ramREN`=1, `ramaddr` = latched word address.
  - On `ramready`, register the result and pulse the hit on the next cycle, then return to IDLE.
  - DREAD result with latched `ldsel`:
    - Byte: `(ramload >> 8*a[1:0]) & 32'hFF`.
    - Halfword: `(ramload >> 16*a[1]) & 32'hFFFF`; `a[0]` is ignored.
    - Word (0/3): `ramload` unchanged.
- DWRITE:
  - `ramWEN`=1, `ramstore` = latched data.
  - On `ramready`, pulse `dhit` next cycle and return to IDLE.
- RMW_RD:
  - `ramREN`=1.
  - On `ramready`, register a merged word: `ramload` with the lane replaced.
    - Byte lane `a[1:0]` (lane 0 = bits 7:0) takes `dstore[7:0]`.
    - Halfword lane `a[1]` takes `dstore[15:0]`.
  - Go to RMW_WR.
- RMW_WR:
  - `ramWEN`=1, `ramstore` = merged word.
  - On `ramready`, pulse `dhit` and return to IDLE. `dload` is unchanged.
- Round-robin (`DPRIORITY`=0): on a tie the pointer's port wins, then the pointer flips. Non-tie grants leave the pointer unchanged.
- HALTED:
  - `halted`=1. No strobes are issued and all requests are ignored.
  - Leaves HALTED only on `RST`.
- `RST` asserted mid-access: all strobes drop immediately (asynchronously) and no hit is produced.
- `ramREN` and `ramWEN` are never high together.

## Timing
- Request sampled at edge N.
- Access state runs from N+1 until `ramready`.
- With `ramready` at cycle N+k, the hit pulse appears in cycle N+k+1.
- Minimum latency is 2 cycles (`ramready` in the first access cycle). RMW minimum is 3 cycles.
- `ramaddr`, `ramstore` and the strobes are stable throughout each access state.
- `ihit` and `dhit` are never high together and each lasts exactly 1 cycle.
- Peak throughput: one access per 3 cycles (accept, access, hit/IDLE).

## Test plan
- Reset/word fetch: `RST` pulse → all outputs 0. Then `iren`=1, `iaddr`=0x104, with `ramready` tied high and `ramload`=0xDEADBEEF → `ramaddr`=0x104, `ramREN` for 1 cycle, `ihit`=1 with `iload`=0xDEADBEEF two cycles after the request.
- Tie arbitration: `iren`+`dren` together with `DPRIORITY`=1 → data served first, then instruction. With `DPRIORITY`=0 → instruction, data, instruction on repeated ties.
- Byte load: `daddr`=0x203, `ldsel`=1, `ramload`=0x11223344 → `dload`=0x00000011. Halfword load at 0x202 → 0x00001122.
- Byte store RMW: `daddr`=0x41, `svsel`=1, `dstore`=0xAB, RAM word 0x11223344 → read at 0x40, then write 0x1122AB44, then `dhit`. With `ramready` delayed 3 cycles per phase, the strobes stay held.
- Halt: `halt` with `iren` in IDLE → no access, `halted`=1 permanently. `halt` during a DWRITE → write completes, `dhit` pulses, then HALTED.
- Reset mid-RMW: `RST` asserted in RMW_RD → `ramREN` drops at once, no `ramWEN`, no `dhit`, state IDLE.
